// File: rtl/xilinx_primitive_pkg.sv
// Shared types and helpers for the Xilinx primitive wrappers.
package xilinx_primitive_pkg;

  // Read-stream adapter control states.
  typedef enum logic [1:0] {
    HOLDOFF,
    IDLE,
    RUN,
    DRAIN
  } rd_stream_state_t;

  // Bits needed to encode values 0..v-1; never returns less than one.
  function automatic int unsigned clog2_safe(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/xilinx_stream_skid_buf.sv
// Circular buffer of DEPTH entries with a registered head word and valid flag.
// DEPTH need not be a power of two; pointers wrap explicitly.
module xilinx_stream_skid_buf
  import xilinx_primitive_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push,
  input  logic [DATA_WIDTH-1:0]             push_data,
  input  logic                              pop,
  output logic                              valid,
  output logic [DATA_WIDTH-1:0]             head,
  output logic [clog2_safe(DEPTH + 1)-1:0]  count
);

  localparam int unsigned PTR_W = clog2_safe(DEPTH);
  localparam int unsigned CNT_W = clog2_safe(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr_n;
  logic [PTR_W-1:0]      rd_ptr_n;
  logic [CNT_W-1:0]      count_n;
  logic [DATA_WIDTH-1:0] head_n;
  logic                  do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next pointers, occupancy and the word that becomes head after this edge.
  always_comb begin
    do_pop   = pop && valid;
    wr_ptr_n = push ? ptr_inc(wr_ptr) : wr_ptr;
    rd_ptr_n = do_pop ? ptr_inc(rd_ptr) : rd_ptr;
    count_n  = count + CNT_W'(push) - CNT_W'(do_pop);
    // A push landing on the new read slot means the buffer was otherwise empty.
    head_n   = (push && (wr_ptr == rd_ptr_n)) ? push_data : mem[rd_ptr_n];
  end

  // Storage, pointers and registered head/valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      head   <= '0;
    end else begin
      if (push) mem[wr_ptr] <= push_data;
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      valid  <= (count_n != '0);
      head   <= head_n;
    end
  end

  overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/xilinx_fifo_rd_stream.sv
// Converts the standard-mode BRAM FIFO read port into a valid/ready stream
// using read credits against a small skid buffer.
module xilinx_fifo_rd_stream
  import xilinx_primitive_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 4,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned SKID_DEPTH   = READ_LATENCY + 1,
  parameter int unsigned RST_HOLDOFF  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_do,
  input  logic                  fifo_rderr,
  output logic                  fifo_rden,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  idle,
  output logic                  rderr_sticky,
  input  logic                  clr_err
);

  localparam int unsigned CNT_W = clog2_safe(SKID_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned HO_W  = clog2_safe(RST_HOLDOFF);

  rd_stream_state_t        state;
  rd_stream_state_t        state_n;
  logic [HO_W-1:0]         ho_cnt;
  logic [HO_W-1:0]         ho_cnt_n;
  logic [READ_LATENCY-1:0] pipe;
  logic [SUM_W-1:0]        inflight;
  logic [SUM_W-1:0]        used;
  logic [CNT_W-1:0]        occ;
  logic                    pop;
  logic                    push;

  // Credit accounting: a pop this cycle frees its slot for a read issued now.
  always_comb begin
    pop      = m_valid && m_ready;
    push     = pipe[READ_LATENCY-1];
    inflight = SUM_W'($countones(pipe));
    used     = SUM_W'(occ) + inflight - SUM_W'(pop);
  end

  // Next-state, hold-off countdown and read enable.
  always_comb begin
    state_n   = state;
    ho_cnt_n  = ho_cnt;
    fifo_rden = 1'b0;
    case (state)
      HOLDOFF: begin
        // Exit takes the IDLE decision in the same clock so the hold-off is exact.
        if (ho_cnt == '0) state_n = en ? RUN : IDLE;
        else              ho_cnt_n = ho_cnt - HO_W'(1);
      end
      IDLE: begin
        if (en) state_n = RUN;
      end
      RUN: begin
        fifo_rden = !fifo_empty && (used < SUM_W'(SKID_DEPTH));
        if (!en) state_n = DRAIN;
      end
      DRAIN: begin
        if (inflight == '0) state_n = IDLE;
      end
      default: state_n = HOLDOFF;
    endcase
  end

  // Control state, in-flight read pipe and error latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HOLDOFF;
      ho_cnt       <= HO_W'(RST_HOLDOFF - 1);
      pipe         <= '0;
      rderr_sticky <= 1'b0;
    end else begin
      state  <= state_n;
      ho_cnt <= ho_cnt_n;
      pipe   <= READ_LATENCY'({pipe, fifo_rden});
      if (fifo_rderr)   rderr_sticky <= 1'b1;
      else if (clr_err) rderr_sticky <= 1'b0;
    end
  end

  assign idle = (state == IDLE) && (inflight == '0) && (occ == '0);

  xilinx_stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (SKID_DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (fifo_do),
    .pop       (pop),
    .valid     (m_valid),
    .head      (m_data),
    .count     (occ)
  );

endmodule

// File: tb/tb_xilinx_fifo_rd_stream.sv
// Bench for the FIFO read-stream adapter: instance A (latency 1, depth 2) and
// instance B (latency 2, depth 3), each fed by a standard-mode FIFO model.
module tb_xilinx_fifo_rd_stream;

  localparam int unsigned DW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          a_en, a_empty, a_rderr, a_rden, a_valid, a_ready, a_idle, a_sticky, a_clr;
  logic [DW-1:0] a_do, a_data;
  logic          b_en, b_empty, b_rderr, b_rden, b_valid, b_ready, b_idle, b_sticky, b_clr;
  logic [DW-1:0] b_do, b_data, b_stage;

  xilinx_fifo_rd_stream #(
    .DATA_WIDTH(DW), .READ_LATENCY(1), .SKID_DEPTH(2), .RST_HOLDOFF(5)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .en(a_en), .fifo_empty(a_empty), .fifo_do(a_do),
    .fifo_rderr(a_rderr), .fifo_rden(a_rden), .m_valid(a_valid), .m_ready(a_ready),
    .m_data(a_data), .idle(a_idle), .rderr_sticky(a_sticky), .clr_err(a_clr)
  );

  xilinx_fifo_rd_stream #(
    .DATA_WIDTH(DW), .READ_LATENCY(2), .SKID_DEPTH(3), .RST_HOLDOFF(5)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .en(b_en), .fifo_empty(b_empty), .fifo_do(b_do),
    .fifo_rderr(b_rderr), .fifo_rden(b_rden), .m_valid(b_valid), .m_ready(b_ready),
    .m_data(b_data), .idle(b_idle), .rderr_sticky(b_sticky), .clr_err(b_clr)
  );

  int total, bad, cyc;
  logic [DW-1:0] fq_a[$], fq_b[$], exp_a[$], exp_b[$];
  logic a_force, b_force;
  int a_rd_cnt, b_rd_cnt, a_first_rd;
  int a_pops, a_first_pop, a_last_pop;
  int b_pops, b_first_pop, b_last_pop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic upd_empty();
    a_empty = (fq_a.size() == 0) || a_force;
    b_empty = (fq_b.size() == 0) || b_force;
  endtask

  // Load n words first..first+n-1 into a FIFO model and expect them in order.
  task automatic load(input int sel, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) begin fq_a.push_back(DW'(first + i)); exp_a.push_back(DW'(first + i)); end
      else          begin fq_b.push_back(DW'(first + i)); exp_b.push_back(DW'(first + i)); end
    end
    upd_empty();
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Called just after a falling edge with rst_n low: release and check hold-off.
  task automatic holdoff_check(input int sel, input string tag);
    rst_n = 1'b1;
    #1;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      check($sformatf("%s_clk%0d", tag, k), (sel == 0) ? a_rden : b_rden, (k == 6) ? 1 : 0);
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    rst_n = 1'b0;
    a_en = 1'b1; a_rderr = 1'b0; a_ready = 1'b1; a_clr = 1'b0; a_force = 1'b0; a_do = '0;
    b_en = 1'b0; b_rderr = 1'b0; b_ready = 1'b0; b_clr = 1'b0; b_force = 1'b0; b_do = '0;
    b_stage = '0;
    a_rd_cnt = 0; b_rd_cnt = 0; a_first_rd = -1;
    a_pops = 0; a_first_pop = -1; a_last_pop = -1;
    b_pops = 0; b_first_pop = -1; b_last_pop = -1;
    upd_empty();

    fork
      // Cycle counter.
      forever begin
        @(posedge clk);
        cyc++;
      end
      // FIFO models: A returns DO one clock after RDEN, B two clocks.
      forever begin
        logic ra, rb;
        @(negedge clk);
        ra = a_rden;
        rb = b_rden;
        if (ra) begin
          check("a_rden_vs_empty", a_empty, 0);
          a_rd_cnt++;
          if (a_first_rd < 0) a_first_rd = cyc;
        end
        if (rb) begin
          check("b_rden_vs_empty", b_empty, 0);
          b_rd_cnt++;
        end
        @(posedge clk);
        #1;
        if (ra && fq_a.size() > 0) a_do = fq_a.pop_front();
        b_do = b_stage;
        if (rb && fq_b.size() > 0) b_stage = fq_b.pop_front();
        upd_empty();
      end
      // Scoreboard monitor: every accepted word must be the next expected one.
      forever begin
        @(negedge clk);
        if (rst_n && a_valid && a_ready) begin
          if (exp_a.size() == 0) check("a_unexpected_word", a_data, 32'hdead);
          else                   check("a_data", a_data, exp_a.pop_front());
          a_pops++;
          if (a_first_pop < 0) a_first_pop = cyc;
          a_last_pop = cyc;
        end
        if (rst_n && b_valid && b_ready) begin
          if (exp_b.size() == 0) check("b_unexpected_word", b_data, 32'hdead);
          else                   check("b_data", b_data, exp_b.pop_front());
          b_pops++;
          if (b_first_pop < 0) b_first_pop = cyc;
          b_last_pop = cyc;
        end
      end
    join_none

    // Reset values, with words 1..8 waiting in FIFO A.
    load(0, 1, 8);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_a_rden", a_rden, 0);
    check("rst_a_valid", a_valid, 0);
    check("rst_a_data", a_data, 0);
    check("rst_a_idle", a_idle, 0);
    check("rst_a_sticky", a_sticky, 0);
    check("rst_b_idle", b_idle, 0);

    // Hold-off, then streaming at one word per clock.
    holdoff_check(0, "a_holdoff");
    for (int t = 0; t < 60 && a_pops < 8; t++) @(negedge clk);
    check("a_stream_count", a_pops, 8);
    check("a_first_latency", a_first_pop - a_first_rd, 2);
    check("a_burst_span", a_last_pop - a_first_pop, 7);
    check("a_reads", a_rd_cnt, 8);
    check("b_idle_after_holdoff", b_idle, 1);

    // Empty flag toggling every 3 clocks while 12 words are available.
    step(1);
    a_force = 1'b1;
    load(0, 1, 12);
    for (int i = 0; i < 12; i++) begin
      step(3);
      a_force = ~a_force;
      upd_empty();
    end
    a_force = 1'b0;
    upd_empty();
    for (int t = 0; t < 60 && exp_a.size() != 0; t++) @(negedge clk);
    check("a_toggle_drained", exp_a.size(), 0);
    check("a_toggle_sticky", a_sticky, 0);

    // Backpressure on B: only SKID_DEPTH reads, then a gap-free release.
    step(1);
    b_rd_cnt = 0;
    load(1, 1, 10);
    b_en = 1'b1;
    repeat (15) @(negedge clk);
    check("b_bp_reads", b_rd_cnt, 3);
    check("b_bp_rden", b_rden, 0);
    check("b_bp_valid", b_valid, 1);
    check("b_bp_head", b_data, 1);
    step(1);
    b_pops = 0; b_first_pop = -1;
    b_ready = 1'b1;
    for (int t = 0; t < 60 && b_pops < 10; t++) @(negedge clk);
    check("b_bp_count", b_pops, 10);
    check("b_bp_span", b_last_pop - b_first_pop, 9);

    // EN dropped with two reads in flight: both delivered, then IDLE.
    step(1);
    b_en = 1'b0;
    for (int t = 0; t < 30 && !b_idle; t++) @(negedge clk);
    check("b_idle_before_drop", b_idle, 1);
    step(1);
    b_rd_cnt = 0;
    load(1, 11, 4);
    b_en = 1'b1;
    for (int t = 0; t < 30 && !b_rden; t++) @(negedge clk);
    check("b_drop_first_rden", b_rden, 1);
    step(1);
    b_en = 1'b0;
    @(negedge clk);
    check("b_drop_idle_busy", b_idle, 0);
    for (int t = 0; t < 30 && !b_idle; t++) @(negedge clk);
    check("b_drop_idle", b_idle, 1);
    repeat (5) @(negedge clk);
    check("b_drop_reads", b_rd_cnt, 2);
    check("b_drop_left_exp", exp_b.size(), 2);
    check("b_drop_valid", b_valid, 0);
    fq_b.delete();
    exp_b.delete();
    upd_empty();

    // Error latch: set, hold, set-wins-over-clear, clear.
    step(1);
    a_rderr = 1'b1;
    step(1);
    a_rderr = 1'b0;
    @(negedge clk);
    check("a_err_set", a_sticky, 1);
    repeat (3) @(negedge clk);
    check("a_err_hold", a_sticky, 1);
    step(1);
    a_rderr = 1'b1; a_clr = 1'b1;
    step(1);
    a_rderr = 1'b0;
    @(negedge clk);
    check("a_err_set_wins", a_sticky, 1);
    step(1);
    a_clr = 1'b0;
    @(negedge clk);
    check("a_err_clear", a_sticky, 0);
    check("b_err_clean", b_sticky, 0);

    // Reset with two words buffered in B, then hold-off restarts.
    step(1);
    b_ready = 1'b0;
    load(1, 1, 2);
    b_en = 1'b1;
    repeat (8) @(negedge clk);
    check("b_buffered_valid", b_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("b_async_valid", b_valid, 0);
    check("b_async_data", b_data, 0);
    check("b_async_rden", b_rden, 0);
    step(1);
    fq_a.delete(); exp_a.delete(); fq_b.delete(); exp_b.delete();
    load(1, 5, 3);
    b_ready = 1'b1;
    @(negedge clk);
    holdoff_check(1, "b_holdoff");
    for (int t = 0; t < 40 && exp_b.size() != 0; t++) @(negedge clk);
    check("b_after_reset_drained", exp_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
